layer6_buf_ctrl: RTL and testbench

- Controller on the other side of the layer6 dual-port SRAM wrapper (64 words x 128 bit, active-low write enables).
- Turns the SRAM into a 64-deep streaming FIFO. Port A is write-only and carries the producer (conv engine) pushes. Port B is read-only and prefetches into a 2-entry output skid buffer that feeds the next layer through a valid/ready handshake.
- Guarantees no same-address A/B access, so the wrapper's collision steering never triggers.

---
 rtl/layer6_buf_ctrl.sv | 103 ++++++++++
 tb/tb_layer6_buf_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/layer6_buf_ctrl.sv
// layer6_buf_ctrl
//   Streaming-FIFO controller for the layer6 dual-port SRAM (2**AW words x DW).
//   Port A is write-only (producer pushes); port B is read-only and prefetches
//   into a 2-entry skid buffer that drives a valid/ready consumer interface.
//   The occupancy counter keeps A and B from ever touching the same word
//   while both ports are active.
//
// Ports
//   CK, RSTN                  clock, synchronous active-low reset
//   clr                       synchronous flush (same effect as reset)
//   in_valid/in_ready/in_data producer side
//   out_valid/out_ready/out_data consumer side (skid head)
//   level                     words held: SRAM + in-flight read + skid
//   sram_A/WEAN/OEA/DIA       SRAM port A (write pointer, active-low WE)
//   sram_B/WEBN/OEB/DOB       SRAM port B (read pointer, read strobe, data)
module layer6_buf_ctrl #(
    parameter int DW = 128,
    parameter int AW = 6
) (
    input  logic          CK,
    input  logic          RSTN,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW+1:0] level,
    output logic [AW-1:0] sram_A,
    output logic          sram_WEAN,
    output logic          sram_OEA,
    output logic [DW-1:0] sram_DIA,
    output logic [AW-1:0] sram_B,
    output logic          sram_WEBN,
    output logic          sram_OEB,
    input  logic [DW-1:0] sram_DOB
);

    localparam logic [AW:0] DEPTH = AW'(1) << AW;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   sram_cnt, sram_cnt_n;
    logic          inflight;
    logic [1:0]    skid_cnt, skid_cnt_n;
    logic          hd;
    logic [DW-1:0] skid_q [2];

    logic          flush, push, pop, issue;
    logic [2:0]    skid_room;

    assign flush = ~RSTN | clr;

    // in_ready depends on registered state only.
    assign in_ready  = (sram_cnt != DEPTH);
    // Writes are suppressed during a flush cycle; the word would be discarded anyway.
    assign push      = in_valid & in_ready & ~flush;
    assign out_valid = (skid_cnt != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = skid_q[hd];

    // Slots already committed to the skid next cycle. A same-cycle pop frees
    // one slot, which is what lets a read issue every cycle while streaming.
    // pop implies skid_cnt >= 1, so the subtraction cannot underflow.
    assign skid_room = {1'b0, skid_cnt} + {2'b0, inflight} - {2'b0, pop};
    assign issue     = (sram_cnt != '0) & (skid_room < 3'd2) & ~flush;

    assign sram_cnt_n = sram_cnt + (AW+1)'(push) - (AW+1)'(issue);
    assign skid_cnt_n = skid_cnt + {1'b0, inflight} - {1'b0, pop};

    assign sram_A    = wr_ptr;
    assign sram_WEAN = ~push;
    assign sram_OEA  = 1'b0;
    assign sram_DIA  = in_data;
    assign sram_B    = rd_ptr;
    assign sram_WEBN = 1'b1;
    assign sram_OEB  = issue;

    always_ff @(posedge CK) begin
        if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            sram_cnt  <= '0;
            inflight  <= 1'b0;   // drops any DOB return still on its way
            skid_cnt  <= '0;
            hd        <= 1'b0;
            skid_q[0] <= '0;
            skid_q[1] <= '0;
            level     <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + AW'(1);
            if (issue) rd_ptr <= rd_ptr + AW'(1);
            inflight <= issue;
            sram_cnt <= sram_cnt_n;
            skid_cnt <= skid_cnt_n;
            // A capture only happens with skid_cnt <= 1, so the tail is hd + skid_cnt.
            if (inflight) skid_q[hd ^ skid_cnt[0]] <= sram_DOB;
            if (pop) hd <= ~hd;
            level <= (AW+2)'(sram_cnt_n) + (AW+2)'(skid_cnt_n) + (AW+2)'(issue);
        end
    end

endmodule

// File: tb/tb_layer6_buf_ctrl.sv
module tb_layer6_buf_ctrl;

    localparam int DW = 128;
    localparam int AW = 6;

    logic          CK = 1'b0;
    logic          RSTN, clr, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data, sram_DIA, sram_DOB;
    logic [AW+1:0] level;
    logic [AW-1:0] sram_A, sram_B;
    logic          sram_WEAN, sram_OEA, sram_WEBN, sram_OEB;

    layer6_buf_ctrl #(.DW(DW), .AW(AW)) dut (
        .CK(CK), .RSTN(RSTN), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level),
        .sram_A(sram_A), .sram_WEAN(sram_WEAN), .sram_OEA(sram_OEA), .sram_DIA(sram_DIA),
        .sram_B(sram_B), .sram_WEBN(sram_WEBN), .sram_OEB(sram_OEB), .sram_DOB(sram_DOB)
    );

    always #5 CK = ~CK;

    // Behavioural SRAM: write on A, registered read on B.
    logic [DW-1:0] mem [64];
    always @(posedge CK) begin
        if (!sram_WEAN) mem[sram_A] <= sram_DIA;
        if (sram_OEB)   sram_DOB <= mem[sram_B];
    end

    int ncmp = 0, nerr = 0;
    int npush = 0, npop = 0, wid = 0;
    logic acc;
    logic [DW-1:0] q [$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes and the collision rule at the falling edge,
    // then step past the rising edge.
    task automatic tick();
        @(negedge CK);
        acc = in_valid && in_ready && RSTN && !clr;
        if (acc) begin q.push_back(in_data); npush++; end
        if (out_valid && out_ready && RSTN && !clr) begin
            npop++;
            if (q.size() == 0) chk("pop_underflow", out_data, 'x);
            else chk("data_order", out_data, q.pop_front());
        end
        chk("no_collision", DW'(!(!sram_WEAN && sram_OEB && sram_A == sram_B)), DW'(1));
        @(posedge CK);
        #1;
    endtask

    task automatic next_word();
        if (acc) begin wid++; in_data = DW'(wid); end
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, DW'(out_valid), DW'(0));
        chk({tag, "_level"},     DW'(level),     DW'(0));
        chk({tag, "_in_ready"},  DW'(in_ready),  DW'(1));
        chk({tag, "_wean"},      DW'(sram_WEAN), DW'(1));
        chk({tag, "_oeb"},       DW'(sram_OEB),  DW'(0));
        chk({tag, "_out_data"},  out_data,       DW'(0));
    endtask

    int base, lvl0;

    initial begin
        RSTN = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; acc = 1'b0;

        // 1: reset, then 5 words with the consumer always ready
        tick(); tick();
        chk_reset_vals("rst");
        chk("tie_oea",  DW'(sram_OEA),  DW'(0));
        chk("tie_webn", DW'(sram_WEBN), DW'(1));
        RSTN = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1; wid = 1; in_data = DW'(1);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) chk("lat_e0", DW'(out_valid), DW'(0));
            if (i == 1) chk("lat_e1", DW'(out_valid), DW'(0));
            if (i == 2) chk("lat_e2", DW'(out_valid), DW'(1));
            next_word();
        end
        drain(10);
        chk("t1_pushed", DW'(npush), DW'(5));
        chk("t1_popped", DW'(npop),  DW'(5));
        chk("t1_level",  DW'(level), DW'(0));

        // 2: backpressure fill to 66, then release
        base = npush; npop = 0;
        out_ready = 1'b0; in_valid = 1'b1; wid = 100; in_data = DW'(100);
        for (int i = 0; i < 80; i++) begin tick(); next_word(); end
        chk("t2_accepted", DW'(npush - base), DW'(66));
        chk("t2_in_ready", DW'(in_ready),     DW'(0));
        chk("t2_level",    DW'(level),        DW'(66));
        chk("t2_out_valid", DW'(out_valid),   DW'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 50 && (npush - base) < 70; i++) begin tick(); next_word(); end
        drain(90);
        chk("t2_popped", DW'(npop),  DW'(70));
        chk("t2_empty",  DW'(q.size()), DW'(0));
        chk("t2_level0", DW'(level), DW'(0));

        // 3: 200 words with random handshakes on both sides
        base = npush; npop = 0; wid = 1000; in_data = DW'(1000);
        for (int i = 0; i < 3000 && (npush - base) < 200; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            tick(); next_word();
        end
        drain(90);
        chk("t3_pushed", DW'(npush - base), DW'(200));
        chk("t3_popped", DW'(npop),  DW'(200));
        chk("t3_level0", DW'(level), DW'(0));

        // 4: fill 10, then full-rate both sides: one word per cycle, level flat
        base = npush; npop = 0; wid = 5000; in_data = DW'(5000);
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin tick(); next_word(); end
        chk("t4_fill_level", DW'(level), DW'(10));
        out_ready = 1'b1;
        lvl0 = npop;
        for (int i = 0; i < 20; i++) begin
            tick(); next_word();
            chk("t4_level_flat", DW'(level), DW'(10));
        end
        chk("t4_rate_out", DW'(npop - lvl0),  DW'(20));
        chk("t4_rate_in",  DW'(npush - base), DW'(30));
        drain(20);
        chk("t4_level0", DW'(level), DW'(0));

        // 5: clr with 30 queued and a read in flight
        npop = 0; wid = 7000; in_data = DW'(7000);
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin tick(); next_word(); end
        in_valid = 1'b0;
        tick(); tick();
        out_ready = 1'b1;
        tick();                       // pops one, issues a read
        out_ready = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0; q.delete();
        chk("t5_clr_level",     DW'(level),     DW'(0));
        chk("t5_clr_out_valid", DW'(out_valid), DW'(0));
        chk("t5_clr_in_ready",  DW'(in_ready),  DW'(1));
        npop = 0;
        in_valid = 1'b1; in_data = DW'(8'hAA); out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t5_no_stale1", DW'(out_valid), DW'(0));
        tick();
        chk("t5_no_stale2", DW'(out_valid), DW'(0));
        drain(10);
        chk("t5_popped", DW'(npop), DW'(1));

        // 6: one-cycle reset mid-stream
        npop = 0; wid = 9000; in_data = DW'(9000);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin tick(); next_word(); end
        in_valid = 1'b0; RSTN = 1'b0;
        tick();
        RSTN = 1'b1; q.delete();
        chk_reset_vals("t6");
        npop = 0;
        in_valid = 1'b1; in_data = DW'(8'h55);
        tick();
        drain(10);
        chk("t6_popped", DW'(npop),  DW'(1));
        chk("t6_level0", DW'(level), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
